inst_fetch_queue: RTL

//  Instruction prefetch buffer between the unified single-ported memory and the IF/ID pipeline register.

---
 rtl/inst_fetch_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction prefetch buffer between the unified single-ported memory and
//   the IF/ID pipeline register. Owns the fetch PC, issues word fetches when
//   the arbiter grants the port, buffers up to DEPTH {pc, inst} pairs and hands
//   them to decode in order. A redirect from EX/MEM flushes and restarts fetch.
//
//   Build option: define FETCH_QUEUE_BYPASS_EN to add a combinational
//   memory -> IF/ID path when the queue is empty (zero fetch-to-decode latency).
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   mem_req        out  fetch request to the memory arbiter
//   mem_addr       out  fetch address (current fetch PC, word aligned)
//   mem_gnt        in   arbiter grant; mem_req & mem_gnt = fetch accepted
//   mem_rdata      in   instruction word, valid in the accepted cycle
//   redirect_valid in   taken branch/jump: flush and restart
//   redirect_pc    in   restart address (bits [1:0] ignored)
//   stall_fetch    in   block new fetches; queue still drains
//   inst_valid     out  head entry valid to IF/ID
//   inst_ready     in   IF/ID accepts head
//   inst_out       out  head instruction (NOP_INST when not valid)
//   inst_pc        out  head PC (0 when not valid)
//   q_count        out  occupancy 0..DEPTH
//
// Handshakes: both sides transfer exactly on the cycle where the request/valid
// and the grant/ready are high together. mem_req and inst_valid never depend
// on mem_gnt or inst_ready respectively (except the optional bypass, where
// inst_valid follows an accepted fetch), and inst_ready while inst_valid=0
// is a no-op.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic [31:0]              mem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall_fetch,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_out,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic fetch_acc;   // fetch accepted by the arbiter this cycle
  logic head_valid;  // registered head entry is presentable
  logic head_pop;    // registered head consumed by IF/ID
  logic push;        // accepted word is written into the queue

  // Low two bits of the redirect target are discarded (word-aligned fetch).
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // rst is low during reset, so this also holds mem_req at 0 while in reset
  // and discards any grant that arrives then.
  assign mem_req    = rst & ~redirect_valid & ~stall_fetch & (count != FULL);
  assign mem_addr   = fetch_pc;
  assign fetch_acc  = mem_req & mem_gnt;
  assign head_valid = (count != '0) & ~redirect_valid;
  assign head_pop   = head_valid & inst_ready;
  assign q_count    = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue + accepted fetch: show the memory word directly. mem_req
  // already excludes redirect, so a redirect still forces inst_valid low.
  logic bypass_hit;
  assign bypass_hit = fetch_acc & (count == '0);
  // A bypassed word taken by decode in the same cycle is never stored.
  assign push       = fetch_acc & ~(bypass_hit & inst_ready);

  always_comb begin
    inst_valid = head_valid | bypass_hit;
    inst_out   = NOP_INST;
    inst_pc    = 32'h0000_0000;
    if (head_valid) begin
      inst_out = inst_mem[rd_ptr];
      inst_pc  = pc_mem[rd_ptr];
    end else if (bypass_hit) begin
      inst_out = mem_rdata;
      inst_pc  = fetch_pc;
    end
  end
`else
  assign push = fetch_acc;

  always_comb begin
    inst_valid = head_valid;
    inst_out   = NOP_INST;
    inst_pc    = 32'h0000_0000;
    if (head_valid) begin
      inst_out = inst_mem[rd_ptr];
      inst_pc  = pc_mem[rd_ptr];
    end
  end
`endif

  // Control state: pointers, occupancy, fetch PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over any push/pop; push is already 0 via mem_req.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // The PC advances on every accepted fetch, including a bypassed one.
      if (fetch_acc) fetch_pc <= fetch_pc + 32'd4;
      if (push)      wr_ptr   <= wr_ptr + AW'(1);
      if (head_pop)  rd_ptr   <= rd_ptr + AW'(1);
      case ({push, head_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries only {pc, inst}; no reset needed since count
  // gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule
